// File: rtl/obstacle_gen.sv
// obstacle_gen: scrolling obstacle-pair generator with LFSR gap placement and pass scoring.
// Five pairs of slots (2k top, 2k+1 bottom) spawn at the right edge and scroll left each run frame.
module obstacle_gen #(
   parameter int          SCREEN_W       = 640,
   parameter int          OBS_W          = 40,
   parameter int          GAP_H          = 160,
   parameter int          SCROLL_SPEED   = 4,
   parameter int          SPAWN_INTERVAL = 90,
   parameter int          UPPER_BOUND    = 20,
   parameter int          LOWER_BOUND    = 460,
   parameter int          PLAYER_X_LEFT  = 160,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       gamemode,
   output logic [9:0][9:0]  obstacle_x_left,
   output logic [9:0][9:0]  obstacle_x_right,
   output logic [9:0][8:0]  obstacle_y_up,
   output logic [9:0][8:0]  obstacle_y_down,
   output logic [9:0]       score
);
   localparam logic [9:0]  XS = 10'(SCREEN_W);
   localparam logic [9:0]  XE = 10'(SCREEN_W + OBS_W);
   localparam logic [9:0]  SS = 10'(SCROLL_SPEED);
   localparam logic [9:0]  PX = 10'(PLAYER_X_LEFT);
   localparam logic [8:0]  YU = 9'(UPPER_BOUND);
   localparam logic [8:0]  YL = 9'(LOWER_BOUND);
   localparam logic [8:0]  GH = 9'(GAP_H);
   localparam logic [15:0] SL = 16'(SPAWN_INTERVAL - 1);

   logic [15:0]     lfsr, spawn_cnt;
   logic [4:0]      valid, passed, free_sel, retire, pass;
   logic [4:0][9:0] xl_nx, xr_nx;
   logic [8:0]      gap_top;
   logic [10:0]     score_sum;
   logic            run, spawn;

   always_comb begin
      run = gamemode == 2'b01;
      spawn = run && spawn_cnt == SL;
      free_sel = ~valid & (valid + 5'd1);
      gap_top = YU + 9'(lfsr[7:0]);
      score_sum = {1'b0, score};
      for (int k = 0; k < 5; k++) begin
         retire[k] = obstacle_x_right[2*k] <= SS;
         xr_nx[k] = obstacle_x_right[2*k] - SS;
         xl_nx[k] = obstacle_x_left[2*k] > SS ? obstacle_x_left[2*k] - SS : 10'd0;
         pass[k] = valid[k] && !retire[k] && !passed[k] && xr_nx[k] < PX;
         score_sum = score_sum + 11'(pass[k]);
      end
   end

   always_ff @(posedge clk)
      lfsr <= rst ? LFSR_SEED : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   // pause/crash modes fall through both branches and hold every register
   always_ff @(posedge clk) begin
      if (rst || gamemode == 2'b00) begin
         spawn_cnt <= SL;
         valid <= '0;
         passed <= '0;
         score <= '0;
         obstacle_x_left <= '0;
         obstacle_x_right <= '0;
         obstacle_y_up <= '0;
         obstacle_y_down <= '0;
      end else if (run) begin
         spawn_cnt <= spawn_cnt == SL ? '0 : spawn_cnt + 16'd1;
         score <= score_sum > 11'd999 ? 10'd999 : score_sum[9:0];
         for (int k = 0; k < 5; k++) begin
            if (spawn && free_sel[k]) begin
               valid[k] <= 1'b1;
               passed[k] <= 1'b0;
               obstacle_x_left[2*k] <= XS;
               obstacle_x_left[2*k+1] <= XS;
               obstacle_x_right[2*k] <= XE;
               obstacle_x_right[2*k+1] <= XE;
               obstacle_y_up[2*k] <= YU;
               obstacle_y_down[2*k] <= gap_top;
               obstacle_y_up[2*k+1] <= gap_top + GH;
               obstacle_y_down[2*k+1] <= YL;
            end else if (valid[k] && retire[k]) begin
               valid[k] <= 1'b0;
               passed[k] <= 1'b0;
               obstacle_x_left[2*k] <= '0;
               obstacle_x_left[2*k+1] <= '0;
               obstacle_x_right[2*k] <= '0;
               obstacle_x_right[2*k+1] <= '0;
               obstacle_y_up[2*k] <= '0;
               obstacle_y_down[2*k] <= '0;
               obstacle_y_up[2*k+1] <= '0;
               obstacle_y_down[2*k+1] <= '0;
            end else if (valid[k]) begin
               obstacle_x_left[2*k] <= xl_nx[k];
               obstacle_x_left[2*k+1] <= xl_nx[k];
               obstacle_x_right[2*k] <= xr_nx[k];
               obstacle_x_right[2*k+1] <= xr_nx[k];
               if (pass[k]) passed[k] <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: directed checks of obstacle_gen timing, scoring, pause, clear and reset.
// A second instance with fast scroll and 1-frame spawns drives the score into saturation.
module tb_obstacle_gen;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      gm = 2'b00;
   logic [1:0]      gm2 = 2'b00;
   logic [9:0][9:0] xl, xr, fxl, fxr;
   logic [9:0][8:0] yu, yd, fyu, fyd;
   logic [9:0]      sc, fsc;
   logic [15:0]     sh;
   int              total = 0;
   int              bad = 0;

   typedef struct {
      logic [1:0] gm;
      int         edges;
      int         xr0;
      int         xl0;
      int         xr1;
      int         sc;
   } vec_t;
   vec_t tab [10];

   obstacle_gen dut (
      .clk(clk), .rst(rst), .gamemode(gm),
      .obstacle_x_left(xl), .obstacle_x_right(xr),
      .obstacle_y_up(yu), .obstacle_y_down(yd), .score(sc)
   );

   obstacle_gen #(.SCROLL_SPEED(600), .SPAWN_INTERVAL(1)) fast (
      .clk(clk), .rst(rst), .gamemode(gm2),
      .obstacle_x_left(fxl), .obstacle_x_right(fxr),
      .obstacle_y_up(fyu), .obstacle_y_down(fyd), .score(fsc)
   );

   always #5 clk = ~clk;

   // reference LFSR, used only to predict spawned gap positions
   always @(posedge clk)
      sh <= rst ? 16'hACE1 : {sh[14:0], sh[15] ^ sh[13] ^ sh[12] ^ sh[10]};

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic chk_slot(input int s, input int exl, input int exr, input int eyu, input int eyd);
      chk($sformatf("slot%0d x_left", s), int'(xl[s]), exl);
      chk($sformatf("slot%0d x_right", s), int'(xr[s]), exr);
      chk($sformatf("slot%0d y_up", s), int'(yu[s]), eyu);
      chk($sformatf("slot%0d y_down", s), int'(yd[s]), eyd);
   endtask

   task automatic chk_zero(input int lo, input int hi);
      for (int s = lo; s <= hi; s++) chk_slot(s, 0, 0, 0, 0);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         gm = tab[i].gm;
         tick(tab[i].edges);
         chk($sformatf("v%0d pair0 x_right", i), int'(xr[0]), tab[i].xr0);
         chk($sformatf("v%0d pair0 x_left", i), int'(xl[0]), tab[i].xl0);
         chk($sformatf("v%0d pair1 x_right", i), int'(xr[2]), tab[i].xr1);
         chk($sformatf("v%0d score", i), int'(sc), tab[i].sc);
      end
   endtask

   initial begin
      int g;
      tab[0] = '{2'b01, 89, 324, 284,   0, 0};
      tab[1] = '{2'b01, 40, 160, 120, 520, 0};
      tab[2] = '{2'b01,  1, 156, 116, 516, 1};
      tab[3] = '{2'b01, 38,   4,   0, 364, 1};
      tab[4] = '{2'b01,  1,   0,   0, 360, 1};
      tab[5] = '{2'b01,  5,   0,   0, 340, 1};
      tab[6] = '{2'b10, 50,   0,   0, 340, 1};
      tab[7] = '{2'b01,  4,   0,   0, 324, 1};
      tab[8] = '{2'b01,  1, 680, 640, 320, 1};
      tab[9] = '{2'b01, 41, 516, 476, 156, 2};

      tick(3);
      chk_zero(0, 9);
      chk("reset score", int'(sc), 0);

      rst = 1'b0;
      gm = 2'b01;
      tick(1);
      chk_slot(0, 640, 680, 20, 245);
      chk_slot(1, 640, 680, 405, 460);
      chk_zero(2, 9);

      run_vecs(0, 0);
      g = 20 + int'(sh[7:0]);
      tick(1);
      chk_slot(2, 640, 680, 20, g);
      chk_slot(3, 640, 680, g + 160, 460);
      chk("spawn90 pair0 x_right", int'(xr[0]), 320);
      run_vecs(1, 9);

      gm = 2'b00;
      tick(1);
      chk_zero(0, 9);
      chk("clear score", int'(sc), 0);
      g = 20 + int'(sh[7:0]);
      gm = 2'b01;
      tick(1);
      chk_slot(0, 640, 680, 20, g);
      chk_slot(1, 640, 680, g + 160, 460);
      chk_zero(2, 9);

      tick(10);
      rst = 1'b1;
      tick(1);
      chk_zero(0, 9);
      chk("midrun reset score", int'(sc), 0);
      rst = 1'b0;
      tick(1);
      chk_slot(0, 640, 680, 20, 245);
      chk_slot(1, 640, 680, 405, 460);

      gm2 = 2'b01;
      for (int n = 1; n <= 1010; n++) begin
         tick(1);
         if (n == 998 || n == 999 || n == 1000 || n == 1001 || n == 1010)
            chk($sformatf("fast score edge %0d", n), int'(fsc), n - 1 > 999 ? 999 : n - 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
